// File: rtl/ptw_cache_pkg.sv
// Shared definitions for the PTW response cache: default field widths,
// the stored entry layout and a pointer-width helper.
package ptw_cache_pkg;

    localparam int DEF_TAG_W = 20;
    localparam int DEF_PPN_W = 32;

    typedef struct packed {
        logic                 valid;
        logic                 error;
        logic [DEF_TAG_W-1:0] tag;
        logic [DEF_PPN_W-1:0] ppn;
    } ptw_entry_t;

    // Bits needed to index n items, never less than one so 1-entry cases still get a real pointer.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/ptw_resp_cache_if.sv
// Fill (per-channel PTW responses), flush and lookup bus of ptw_resp_cache.
// master drives requests, slave is the cache.
interface ptw_resp_cache_if #(
    parameter int NUM_CH = 2,
    parameter int TAG_W  = ptw_cache_pkg::DEF_TAG_W,
    parameter int PPN_W  = ptw_cache_pkg::DEF_PPN_W
);
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH-1:0]       in_ready;
    logic [NUM_CH-1:0]       in_error;
    logic [NUM_CH*TAG_W-1:0] in_tag;
    logic [NUM_CH*PPN_W-1:0] in_ppn;
    logic                    flush;
    logic                    lookup_valid;
    logic [TAG_W-1:0]        lookup_tag;
    logic                    resp_valid;
    logic                    resp_hit;
    logic                    resp_error;
    logic [PPN_W-1:0]        resp_ppn;

    modport master (
        output in_valid, in_error, in_tag, in_ppn, flush, lookup_valid, lookup_tag,
        input  in_ready, resp_valid, resp_hit, resp_error, resp_ppn
    );

    modport slave (
        input  in_valid, in_error, in_tag, in_ppn, flush, lookup_valid, lookup_tag,
        output in_ready, resp_valid, resp_hit, resp_error, resp_ppn
    );
endinterface

// File: rtl/ptw_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer; the pointer advances past the winner only when a grant is issued.
module ptw_rr_arbiter
    import ptw_cache_pkg::*;
#(
    parameter int NUM_CH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [NUM_CH-1:0] req,
    output logic [NUM_CH-1:0] grant
);
    localparam int            PW   = clog2_min1(NUM_CH);
    localparam logic [PW-1:0] LAST = PW'(NUM_CH - 1);

    logic [PW-1:0] ptr_reg;
    logic [PW-1:0] ptr_next;
    logic [PW-1:0] idx;
    logic [PW-1:0] gidx;
    logic          found;

    always_comb begin
        grant    = '0;
        found    = 1'b0;
        gidx     = '0;
        idx      = '0;
        // Explicit modulo so non-power-of-two channel counts wrap correctly.
        for (int k = 0; k < NUM_CH; k++) begin
            if (int'(ptr_reg) + k >= NUM_CH)
                idx = PW'(int'(ptr_reg) + k - NUM_CH);
            else
                idx = PW'(int'(ptr_reg) + k);
            if (enable && !found && req[idx]) begin
                found      = 1'b1;
                gidx       = idx;
                grant[idx] = 1'b1;
            end
        end
        ptr_next = ptr_reg;
        if (found)
            ptr_next = (gidx == LAST) ? '0 : gidx + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ptr_reg <= '0;
        else
            ptr_reg <= ptr_next;
    end

endmodule

// File: rtl/ptw_resp_cache.sv
// Multi-channel PTW response cache: round-robin fill, fully-associative FIFO-replaced
// entries, 1-cycle registered lookup. Optional PTW_CACHE_STATS_EN adds hit/miss counters.
module ptw_resp_cache
    import ptw_cache_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int ENTRIES = 4,
    parameter int TAG_W   = DEF_TAG_W,
    parameter int PPN_W   = DEF_PPN_W
) (
    input  logic          clk,
    input  logic          reset,
    ptw_resp_cache_if.slave bus
`ifdef PTW_CACHE_STATS_EN
    ,
    output logic [31:0]   stat_hits,
    output logic [31:0]   stat_misses
`endif
);
    localparam int            EW         = clog2_min1(ENTRIES);
    localparam logic [EW-1:0] LAST_ENTRY = EW'(ENTRIES - 1);

    // Entries use the package layout; TAG_W/PPN_W must not exceed its field widths.
    ptw_entry_t        entry_reg [ENTRIES];
    logic [EW-1:0]     rep_ptr_reg;
    logic [NUM_CH-1:0] grant;
    logic              fill_valid;
    logic [TAG_W-1:0]  fill_tag;
    logic [PPN_W-1:0]  fill_ppn;
    logic              fill_error;
    logic [ENTRIES-1:0] fill_match;
    logic [ENTRIES-1:0] look_match;
    logic              look_error;
    logic [PPN_W-1:0]  look_ppn;
    logic              resp_valid_reg;
    logic              resp_hit_reg;
    logic              resp_error_reg;
    logic [PPN_W-1:0]  resp_ppn_reg;

    ptw_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .clk    (clk),
        .reset  (reset),
        .enable (!bus.flush),
        .req    (bus.in_valid),
        .grant  (grant)
    );

    assign bus.in_ready = grant;
    assign fill_valid   = |grant;

    always_comb begin
        fill_tag   = '0;
        fill_ppn   = '0;
        fill_error = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant[c]) begin
                fill_tag   = bus.in_tag[c*TAG_W +: TAG_W];
                fill_ppn   = bus.in_ppn[c*PPN_W +: PPN_W];
                fill_error = bus.in_error[c];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_cmp
            assign fill_match[gi] = entry_reg[gi].valid && (entry_reg[gi].tag[TAG_W-1:0] == fill_tag);
            assign look_match[gi] = entry_reg[gi].valid && (entry_reg[gi].tag[TAG_W-1:0] == bus.lookup_tag);
        end
    endgenerate

    // Tags are unique, so at most one match bit is set and an OR-mux is enough.
    always_comb begin
        look_error = 1'b0;
        look_ppn   = '0;
        for (int e = 0; e < ENTRIES; e++) begin
            if (look_match[e]) begin
                look_error = look_error | entry_reg[e].error;
                look_ppn   = look_ppn | entry_reg[e].ppn[PPN_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int e = 0; e < ENTRIES; e++)
                entry_reg[e] <= '0;
            rep_ptr_reg    <= '0;
            resp_valid_reg <= 1'b0;
            resp_hit_reg   <= 1'b0;
            resp_error_reg <= 1'b0;
            resp_ppn_reg   <= '0;
        end else begin
            resp_valid_reg <= bus.lookup_valid;
            resp_hit_reg   <= bus.lookup_valid & (|look_match);
            resp_error_reg <= bus.lookup_valid & look_error;
            resp_ppn_reg   <= bus.lookup_valid ? look_ppn : '0;
            if (bus.flush) begin
                for (int e = 0; e < ENTRIES; e++)
                    entry_reg[e].valid <= 1'b0;
                rep_ptr_reg <= '0;
            end else if (fill_valid) begin
                if (|fill_match) begin
                    // Refresh in place: FIFO age order is unchanged.
                    for (int e = 0; e < ENTRIES; e++) begin
                        if (fill_match[e]) begin
                            entry_reg[e].error <= fill_error;
                            entry_reg[e].ppn   <= DEF_PPN_W'(fill_ppn);
                        end
                    end
                end else begin
                    entry_reg[rep_ptr_reg] <= '{valid: 1'b1, error: fill_error,
                                                tag: DEF_TAG_W'(fill_tag), ppn: DEF_PPN_W'(fill_ppn)};
                    rep_ptr_reg <= (rep_ptr_reg == LAST_ENTRY) ? '0 : rep_ptr_reg + 1'b1;
                end
            end
        end
    end

    assign bus.resp_valid = resp_valid_reg;
    assign bus.resp_hit   = resp_hit_reg;
    assign bus.resp_error = resp_error_reg;
    assign bus.resp_ppn   = resp_ppn_reg;

`ifdef PTW_CACHE_STATS_EN
    logic [31:0] stat_hits_reg;
    logic [31:0] stat_misses_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_hits_reg   <= '0;
            stat_misses_reg <= '0;
        end else begin
            if (resp_valid_reg && resp_hit_reg && (stat_hits_reg != 32'hFFFF_FFFF))
                stat_hits_reg <= stat_hits_reg + 32'd1;
            if (resp_valid_reg && !resp_hit_reg && (stat_misses_reg != 32'hFFFF_FFFF))
                stat_misses_reg <= stat_misses_reg + 32'd1;
        end
    end

    assign stat_hits   = stat_hits_reg;
    assign stat_misses = stat_misses_reg;
`endif

endmodule
